// File: rtl/trace_pkg.sv
// Shared types and widths for the trace arbiter: default sizes, source-index
// width helper and the record layout delivered to the log writer.
package trace_pkg;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SEQ_W   = 16;

  // Source-index width; a single source still needs one bit on the port.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SRC_W = src_w(DEF_NUM_SRC);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_SRC_W-1:0] src;
    logic [DEF_SEQ_W-1:0] seq;
  } trace_rec_t;

endpackage

// File: rtl/trace_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping from the top index back to zero.
module trace_rr_pick
  import trace_pkg::*;
#(
  parameter int N  = DEF_NUM_SRC,
  parameter int SW = src_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_grant_idx,
  output logic [N-1:0]  o_grant_oh,
  output logic          o_any
);

  always_comb begin
    logic [SW:0]   w_sum;
    logic [SW-1:0] w_idx;
    o_grant_idx = '0;
    o_grant_oh  = '0;
    o_any       = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    // Scan from the farthest offset down so the nearest request is assigned last.
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (SW + 1)'(k);
      if (w_sum >= (SW + 1)'(N)) begin
        w_sum = w_sum - (SW + 1)'(N);
      end
      w_idx = w_sum[SW-1:0];
      if (i_req[w_idx]) begin
        o_grant_idx        = w_idx;
        o_grant_oh         = '0;
        o_grant_oh[w_idx]  = 1'b1;
        o_any              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trace_arbiter.sv
// Serialises per-source one-deep probe slots into a single registered
// valid/ready record stream; probes never stall, overflows are flagged.
module trace_arbiter
  import trace_pkg::*;
#(
  parameter  int NUM_SRC = DEF_NUM_SRC,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int SEQ_W   = DEF_SEQ_W,
  localparam int SRC_W   = src_w(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_en,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [NUM_SRC-1:0]       pending,
  output logic [NUM_SRC-1:0]       ovf,
  input  logic                     ovf_clr
);

  logic [WIDTH-1:0]   r_slot_data [NUM_SRC];
  logic [NUM_SRC-1:0] r_slot_full;
  logic [NUM_SRC-1:0] r_ovf;
  logic [SRC_W-1:0]   r_ptr;
  logic [SEQ_W-1:0]   r_seq;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SRC_W-1:0]   r_out_src;
  logic [SEQ_W-1:0]   r_out_seq;

  logic               w_free;
  logic               w_issue;
  logic               w_any;
  logic [SRC_W-1:0]   w_grant_idx;
  logic [NUM_SRC-1:0] w_grant_oh;
  logic [SRC_W-1:0]   w_ptr_next;
  logic [NUM_SRC-1:0] w_issued;
  logic [NUM_SRC-1:0] w_capture;
  logic [NUM_SRC-1:0] w_drop;

  trace_rr_pick #(
    .N  (NUM_SRC),
    .SW (SRC_W)
  ) u_pick (
    .i_req       (r_slot_full),
    .i_ptr       (r_ptr),
    .o_grant_idx (w_grant_idx),
    .o_grant_oh  (w_grant_oh),
    .o_any       (w_any)
  );

  assign w_free     = !r_out_valid || out_ready;
  assign w_issue    = w_free && w_any;
  assign w_ptr_next = (w_grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_grant_idx + 1'b1;

  // A slot being issued this edge counts as free, so back-to-back samples flow.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_issued[gi]  = w_issue && w_grant_oh[gi];
    assign w_capture[gi] = trace_en && src_valid[gi] && (!r_slot_full[gi] || w_issued[gi]);
    assign w_drop[gi]    = trace_en && src_valid[gi] && r_slot_full[gi] && !w_issued[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_full <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_capture[i]) begin
          r_slot_data[i] <= src_data[i*WIDTH +: WIDTH];
          r_slot_full[i] <= 1'b1;
        end else if (w_issued[i]) begin
          r_slot_full[i] <= 1'b0;
        end
      end
    end
  end

  // A fresh overflow outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= w_drop | (ovf_clr ? '0 : r_ovf);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_seq   <= '0;
      r_seq       <= '0;
      r_ptr       <= '0;
    end else if (w_free) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= r_slot_data[w_grant_idx];
        r_out_src  <= w_grant_idx;
        r_out_seq  <= r_seq;
        r_seq      <= r_seq + 1'b1;
        r_ptr      <= w_ptr_next;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_seq   = r_out_seq;
  assign pending   = r_slot_full;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_trace_arbiter.sv
// Self-checking bench for trace_arbiter: scoreboard of expected records plus
// a table of per-cycle status vectors and hand-written corner sequences.
module tb_trace_arbiter;
  import trace_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         trace_en;
  logic [3:0]   src_valid;
  logic [127:0] src_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic [15:0]  out_seq;
  logic [3:0]   pending;
  logic [3:0]   ovf;
  logic         ovf_clr;

  int n_checks = 0;
  int n_errors = 0;
  bit quiet    = 1'b0;

  trace_rec_t sb[$];

  typedef struct {
    logic        en;
    logic [3:0]  sv;
    logic [31:0] d;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ep;
    logic [3:0]  eo;
  } vec_t;

  vec_t vecs[12];

  trace_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trace_en  (trace_en),
    .src_valid (src_valid),
    .src_data  (src_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_seq   (out_seq),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] s, input logic [15:0] q);
    trace_rec_t r;
    r.data = d;
    r.src  = s;
    r.seq  = q;
    sb.push_back(r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Records transfer on the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      trace_rec_t act;
      trace_rec_t exp;
      act.data = out_data;
      act.src  = out_src;
      act.seq  = out_seq;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL rec_unexpected: got data=%h src=%0d seq=%0d, want no record", out_data, out_src, out_seq);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL rec: got data=%h src=%0d seq=%0d, want data=%h src=%0d seq=%0d",
                   act.data, act.src, act.seq, exp.data, exp.src, exp.seq);
        end else if (!quiet || act.seq == 16'd0 || act.seq == 16'hFFFF) begin
          $display("rec data=%h src=%0d seq=%0d ok", act.data, act.src, act.seq);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    trace_en  = 1'b1;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (3) tick();

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_src", {30'd0, out_src}, 32'd0);
    chk("rst_out_seq", {16'd0, out_seq}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_ovf", {28'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single sample on source 2.
    src_valid = 4'b0100;
    src_data[64 +: 32] = 32'hDEADBEEF;
    push(32'hDEADBEEF, 2'd2, 16'd0);
    tick();
    src_valid = '0;
    chk("single_pending", {28'd0, pending}, 32'h4);
    chk("single_valid_e0", {31'd0, out_valid}, 32'd0);
    tick();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_src", {30'd0, out_src}, 32'd2);
    chk("single_seq", {16'd0, out_seq}, 32'd0);
    tick();
    chk("single_valid_after", {31'd0, out_valid}, 32'd0);
    $display("single sample done");

    // Reset while a record is held and two slots are full.
    out_ready = 1'b0;
    src_valid = 4'b0001;
    src_data  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    tick();
    src_valid = 4'b1010;
    tick();
    src_valid = '0;
    chk("prerst_valid", {31'd0, out_valid}, 32'd1);
    chk("prerst_pending", {28'd0, pending}, 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("asyncrst_valid", {31'd0, out_valid}, 32'd0);
    chk("asyncrst_pending", {28'd0, pending}, 32'd0);
    chk("asyncrst_ovf", {28'd0, ovf}, 32'd0);
    chk("asyncrst_data", out_data, 32'd0);
    $display("async reset done");
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Fairness: all sources at once, then a wrap-around pair.
    src_valid = 4'hF;
    src_data  = {32'h13, 32'h12, 32'h11, 32'h10};
    for (int k = 0; k < 4; k++) push(32'h10 + k, 2'(k), 16'(k));
    tick();
    src_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fair_valid", {31'd0, out_valid}, 32'd1);
      chk("fair_src", {30'd0, out_src}, k);
    end
    src_valid = 4'b1001;
    src_data  = {32'h23, 32'h0, 32'h0, 32'h20};
    push(32'h20, 2'd0, 16'd4);
    push(32'h23, 2'd3, 16'd5);
    tick();
    src_valid = '0;
    tick();
    chk("pair_first_src", {30'd0, out_src}, 32'd0);
    tick();
    chk("pair_second_src", {30'd0, out_src}, 32'd3);
    tick();
    chk("pair_idle", {31'd0, out_valid}, 32'd0);
    $display("fairness done");

    // Backpressure, overflow, clear priority and capture gating.
    vecs[0]  = '{1'b1, 4'b0010, 32'hA0, 1'b0, 1'b0, 1'b0, 32'h0,  4'b0010, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0010, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA0, 4'b0010, 4'b0000};
    vecs[2]  = '{1'b1, 4'b0010, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA0, 4'b0010, 4'b0010};
    vecs[3]  = '{1'b1, 4'b0000, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA1, 4'b0000, 4'b0010};
    vecs[4]  = '{1'b1, 4'b0000, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  4'b0000, 4'b0010};
    vecs[5]  = '{1'b1, 4'b0001, 32'hB0, 1'b0, 1'b0, 1'b0, 32'h0,  4'b0001, 4'b0010};
    vecs[6]  = '{1'b1, 4'b0001, 32'hB1, 1'b0, 1'b0, 1'b1, 32'hB0, 4'b0001, 4'b0010};
    vecs[7]  = '{1'b1, 4'b0001, 32'hB2, 1'b0, 1'b1, 1'b1, 32'hB0, 4'b0001, 4'b0001};
    vecs[8]  = '{1'b1, 4'b0000, 32'h0,  1'b0, 1'b1, 1'b1, 32'hB0, 4'b0001, 4'b0000};
    vecs[9]  = '{1'b0, 4'b1111, 32'hEE, 1'b0, 1'b0, 1'b1, 32'hB0, 4'b0001, 4'b0000};
    vecs[10] = '{1'b0, 4'b1111, 32'hEE, 1'b1, 1'b0, 1'b1, 32'hB1, 4'b0000, 4'b0000};
    vecs[11] = '{1'b0, 4'b1111, 32'hEE, 1'b1, 1'b0, 1'b0, 32'h0,  4'b0000, 4'b0000};
    push(32'hA0, 2'd1, 16'd6);
    push(32'hA1, 2'd1, 16'd7);
    push(32'hB0, 2'd0, 16'd8);
    push(32'hB1, 2'd0, 16'd9);
    for (int v = 0; v < 12; v++) begin
      trace_en  = vecs[v].en;
      src_valid = vecs[v].sv;
      src_data  = {4{vecs[v].d}};
      out_ready = vecs[v].rdy;
      ovf_clr   = vecs[v].clr;
      tick();
      chk($sformatf("vec%0d_valid", v), {31'd0, out_valid}, {31'd0, vecs[v].ev});
      if (vecs[v].ev) chk($sformatf("vec%0d_data", v), out_data, vecs[v].ed);
      chk($sformatf("vec%0d_pending", v), {28'd0, pending}, {28'd0, vecs[v].ep});
      chk($sformatf("vec%0d_ovf", v), {28'd0, ovf}, {28'd0, vecs[v].eo});
      $display("vec %0d: valid=%0d data=%h pending=%b ovf=%b", v, out_valid, out_data, pending, ovf);
    end
    trace_en  = 1'b1;
    src_valid = '0;
    ovf_clr   = 1'b0;
    out_ready = 1'b1;

    // Sequence wrap: 65538 back-to-back records from a fresh reset.
    do_reset();
    quiet = 1'b1;
    for (int k = 0; k < 65538; k++) begin
      src_valid = 4'b0001;
      src_data  = {96'd0, 32'(k)};
      push(32'(k), 2'd0, 16'(k));
      tick();
    end
    src_valid = '0;
    for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
    chk("sb_drained", sb.size(), 32'd0);
    chk("wrap_last_seq", {16'd0, out_seq}, 32'd1);
    quiet = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Shares one trace/log sink between NUM_SRC non-stalling probe sources (register, PC and bus monitors in the CPU datapath).
- Each source owns a one-deep holding slot. A round-robin scheduler serialises the slots into a single registered valid/ready record stream.
- Each record carries its source ID and a sequence number, and drives the downstream file/log writer.
- Probes never stall the CPU. When a slot is full, the new sample is dropped and a sticky per-source overflow flag is set.

Parameters:
NUM_SRC, 4, number of probe sources (2..16; need not be a power of 2)
WIDTH, 32, sample data width in bits
SEQ_W, 16, width of the record sequence counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
trace_en  in  1  1 = capture enabled; 0 = no new captures, draining continues
src_valid  in  NUM_SRC  per-source sample strobe, one sample per cycle per source
src_data  in  NUM_SRC*WIDTH  packed samples; source i occupies bits [i*WIDTH +: WIDTH]
out_valid  out  1  record available
out_ready  in  1  sink accepts the record when out_valid && out_ready
out_data  out  WIDTH  record payload
out_src  out  clog2(NUM_SRC) (min 1)  originating source index
out_seq  out  SEQ_W  record sequence number
pending  out  NUM_SRC  slot-full status per source
ovf  out  NUM_SRC  sticky overflow flag per source
ovf_clr  in  1  synchronous clear of all ovf bits

Behaviour:
- Reset (async assert, sync release): slots empty, pending=0, out_valid=0, out_data=0, out_src=0, out_seq=0, seq counter=0, rr pointer=0, ovf=0.
- Output stage free when !out_valid || out_ready.
- Issue, when the output stage is free:
  - Pick the first full slot scanning from ptr upward, wrapping NUM_SRC-1 -> 0.
  - Load out_data, out_src and out_seq from that slot; out_valid <= 1.
  - Clear the slot, seq <= seq+1, ptr <= (grant+1) mod NUM_SRC.
  - If no slot is full, out_valid <= 0 and ptr is unchanged.
- Output hold: while out_valid && !out_ready, out_data, out_src and out_seq are stable, and no issue occurs.
- Capture, per source i: trace_en && src_valid[i] && (slot i empty || slot i issued this cycle) -> slot <= src_data[i], slot marked full.
  - Capture and issue of the same slot in one edge: the slot stays full with the new sample.
  - trace_en && src_valid[i] && slot full && not issued -> sample discarded, slot keeps the older sample, ovf[i] <= 1.
- Latency: sample captured at edge E0 -> out_valid/out_data visible after edge E1 when the output is free and the source wins arbitration. Minimum latency is 1 cycle from capture.
- Throughput: one record per cycle when out_ready=1.
- ovf_clr: clears all bits; a new overflow in the same cycle wins (that bit reads 1).
- Sequence counter wraps from 2^SEQ_W-1 to 0 and counts issued records only.
- trace_en=0: src_valid is ignored and causes no ovf; already-full slots still drain.
- Reset mid-record: a pending record is lost; out_valid drops immediately on rst_n low.

Decomposition:
- Shared package trace_pkg:
  - SRC_W = clog2(NUM_SRC) helper function (min 1).
  - trace_rec_t struct {data, src, seq}.
  - Default width constants.
- Sub-module trace_rr_pick: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: grant index, grant one-hot, any-grant.

Test Plan:
- Reset: assert rst_n=0 while out_valid=1 and pending=4'b1010 -> out_valid=0, pending=0, ovf=0 without waiting for a clk edge.
- Single sample: src_valid=4'b0100, src_data[2]=32'hDEADBEEF for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=DEADBEEF, out_src=2, out_seq=0; following cycle out_valid=0.
- Fairness: all four sources pulse once with data 0x10..0x13, ptr=0 -> records src0,1,2,3 on consecutive cycles, seq 0..3. Then src3 and src0 pulse together -> src0 first, then src3 (ptr=0 after wrap).
- Backpressure/overflow: out_ready=0; src1 valid on 3 consecutive cycles with 0xA0, 0xA1, 0xA2 -> out_data=0xA0 held, slot=0xA1, 0xA2 dropped, ovf[1]=1. Release out_ready -> records 0xA0 then 0xA1.
- ovf_clr set on the same cycle as a new overflow on src0 -> ovf[0]=1. Next cycle ovf_clr alone -> ovf=0.
- Gate and wrap: trace_en=0 with src_valid=4'hF -> no records, pending and ovf unchanged. Issue 65536 records -> out_seq returns to 0 on record 65537.
